// File: rtl/card_pkg.sv
// Shared card types and constants for the baccarat dealer front end.
package card_pkg;
  localparam int CARD_W     = 4;
  localparam int HAND_SLOTS = 3;

  typedef logic [CARD_W-1:0] card_t;

  localparam card_t CARD_BLANK = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_KING  = 4'd13;

  localparam logic HAND_PLAYER = 1'b0;
  localparam logic HAND_DEALER = 1'b1;
endpackage

// File: rtl/card_rng_counter.sv
// Free-running 1..13 card counter used as the pseudo-random card source.
module card_rng_counter
  import card_pkg::*;
(
  input  logic  clock,
  input  logic  resetb,
  output card_t count
);

  card_t r_count;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_count <= CARD_ACE;
    end else if (r_count == CARD_KING) begin
      r_count <= CARD_ACE;
    end else begin
      r_count <= r_count + card_t'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/card_deal_bank.sv
// Player/dealer slot banks: deals latch the running card count into the next
// empty slot; clear has priority over a same-cycle deal.
module card_deal_bank
  import card_pkg::*;
(
  input  logic                           clock,
  input  logic                           resetb,
  input  logic                           deal_valid,
  input  logic                           deal_hand,
  input  logic                           clear,
  output logic [HAND_SLOTS*CARD_W-1:0]   pcard,
  output logic [HAND_SLOTS*CARD_W-1:0]   dcard,
  output logic [1:0]                     pcount,
  output logic [1:0]                     dcount,
  output logic                           deal_ack,
  output card_t                          deal_card,
  output logic                           deal_err
);

  card_t                         w_card;
  logic [HAND_SLOTS*CARD_W-1:0]  r_pcard;
  logic [HAND_SLOTS*CARD_W-1:0]  r_dcard;
  logic [1:0]                    r_pcount;
  logic [1:0]                    r_dcount;
  logic                          r_ack;
  logic                          r_err;
  card_t                         r_card;

  card_rng_counter u_rng (
    .clock  (clock),
    .resetb (resetb),
    .count  (w_card)
  );

  // ack/err are single-cycle pulses; deal_card only moves on an accepted deal.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_pcard  <= '0;
      r_dcard  <= '0;
      r_pcount <= 2'd0;
      r_dcount <= 2'd0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_card   <= CARD_BLANK;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      if (clear) begin
        r_pcard  <= '0;
        r_dcard  <= '0;
        r_pcount <= 2'd0;
        r_dcount <= 2'd0;
      end else if (deal_valid) begin
        if (deal_hand == HAND_DEALER) begin
          if (r_dcount != 2'd3) begin
            r_dcard[{r_dcount, 2'b00} +: CARD_W] <= w_card;
            r_dcount <= r_dcount + 2'd1;
            r_ack    <= 1'b1;
            r_card   <= w_card;
          end else begin
            r_err <= 1'b1;
          end
        end else begin
          if (r_pcount != 2'd3) begin
            r_pcard[{r_pcount, 2'b00} +: CARD_W] <= w_card;
            r_pcount <= r_pcount + 2'd1;
            r_ack    <= 1'b1;
            r_card   <= w_card;
          end else begin
            r_err <= 1'b1;
          end
        end
      end
    end
  end

  assign pcard     = r_pcard;
  assign dcard     = r_dcard;
  assign pcount    = r_pcount;
  assign dcount    = r_dcount;
  assign deal_ack  = r_ack;
  assign deal_err  = r_err;
  assign deal_card = r_card;

endmodule
